ll_sc_monitor: RTL

Reservation monitor for the LL/SC atomic pair. It records the link address on LL and watches this core's own stores and snooped writes from other bus masters, and it drops the link on any conflict, on flush/ERET, or after a timeout. It resolves each SC with a success/fail result and issues the conditional store to the data bus only on success. It sits beside the MEM stage: MEM holds an SC until `sc_done_o`, and the pipeline stalls through `stallreq_o`.

---
 rtl/ll_sc_monitor_if.sv | 40 ++++
 rtl/ll_sc_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ll_sc_monitor_if.sv
// rtl/ll_sc_monitor_if.sv - pipeline, snoop and data-bus signals of the LL/SC reservation monitor
interface ll_sc_monitor_if;
  // pipeline side
  logic        flush;
  logic        ll_req;
  logic        sc_req;
  logic        st_req;
  logic [31:0] addr;
  logic [31:0] sc_wdata;
  logic        stallreq_o;
  logic        sc_done_o;
  logic        sc_success_o;
  logic        LLbit_o;
  logic [31:0] link_addr_o;
  // snoop side
  logic        snoop_valid;
  logic        snoop_we;
  logic [31:0] snoop_addr;
  // data-bus side
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;

  // master: pipeline/bus environment driving the monitor
  modport master (
    output flush, ll_req, sc_req, st_req, addr, sc_wdata,
    output snoop_valid, snoop_we, snoop_addr, mem_ack_i,
    input  stallreq_o, sc_done_o, sc_success_o, LLbit_o, link_addr_o,
    input  mem_req_o, mem_addr_o, mem_wdata_o
  );

  // slave: the reservation monitor itself
  modport slave (
    input  flush, ll_req, sc_req, st_req, addr, sc_wdata,
    input  snoop_valid, snoop_we, snoop_addr, mem_ack_i,
    output stallreq_o, sc_done_o, sc_success_o, LLbit_o, link_addr_o,
    output mem_req_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/ll_sc_monitor.sv
// rtl/ll_sc_monitor.sv - LL/SC reservation monitor with snoop, own-store, flush and timeout link kill
module ll_sc_monitor #(
  parameter int GRANULE_BITS = 4,
  parameter int LINK_TIMEOUT = 1023
) (
  input logic             clk,
  input logic             rst,
  ll_sc_monitor_if.slave  bus
);

  localparam int CNT_W = $clog2(LINK_TIMEOUT + 1);
  // the link dies on the cycle after the counter has counted LINK_TIMEOUT-1 idle cycles,
  // so LLbit_o falls exactly LINK_TIMEOUT cycles after it rose
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LINKED  = 2'd1,
    SC_WAIT = 2'd2,
    SC_RESP = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [31:0]      link_addr;
  logic [31:0]      link_addr_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             flush_seen;
  logic             flush_seen_nx;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_addr_nx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_wdata_nx;
  logic             result_nx;

  logic             ll_bit_q;
  logic             mem_req_q;
  logic             sc_done_q;
  logic             sc_success_q;

  logic             snoop_hit;
  logic             st_hit;
  logic             sc_match;

  // granule-level conflict detection against the held link address
  assign snoop_hit = bus.snoop_valid & bus.snoop_we &
                     (bus.snoop_addr[31:GRANULE_BITS] == link_addr[31:GRANULE_BITS]);
  assign st_hit    = bus.st_req & (bus.addr[31:GRANULE_BITS] == link_addr[31:GRANULE_BITS]);
  assign sc_match  = (bus.addr[31:GRANULE_BITS] == link_addr[31:GRANULE_BITS]);

  // next-state and datapath-capture logic for the link/SC sequencer
  always_comb begin
    state_nx      = state;
    link_addr_nx  = link_addr;
    cnt_nx        = cnt;
    flush_seen_nx = flush_seen;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    result_nx     = 1'b0;
    unique case (state)
      IDLE: begin
        // an SC without a link always fails; SC also wins over a stray LL
        if (bus.sc_req) begin
          state_nx = SC_RESP;
        end else if (bus.ll_req && !bus.flush) begin
          state_nx     = LINKED;
          link_addr_nx = bus.addr;
          cnt_nx       = '0;
        end
      end
      LINKED: begin
        if (bus.flush) begin
          state_nx = IDLE;
        end else if (bus.sc_req) begin
          // a conflicting write in the same cycle as the SC defeats it
          if (sc_match && !snoop_hit && !st_hit) begin
            state_nx      = SC_WAIT;
            mem_addr_nx   = bus.addr;
            mem_wdata_nx  = bus.sc_wdata;
            flush_seen_nx = 1'b0;
          end else begin
            state_nx = SC_RESP;
          end
        end else if (bus.ll_req) begin
          // re-link; the new link is not killed by a same-cycle snoop of the old one
          link_addr_nx = bus.addr;
          cnt_nx       = '0;
        end else if (snoop_hit || st_hit) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      SC_WAIT: begin
        // the bus request cannot be withdrawn; a flush only suppresses the completion pulse
        if (bus.flush) begin
          flush_seen_nx = 1'b1;
        end
        if (bus.mem_ack_i) begin
          flush_seen_nx = 1'b0;
          if (flush_seen || bus.flush) begin
            state_nx = IDLE;
          end else begin
            state_nx  = SC_RESP;
            result_nx = 1'b1;
          end
        end
      end
      SC_RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // state, link, counter and bus-capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      link_addr  <= '0;
      cnt        <= '0;
      flush_seen <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      link_addr  <= link_addr_nx;
      cnt        <= cnt_nx;
      flush_seen <= flush_seen_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
    end
  end

  // registered status outputs decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ll_bit_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      sc_done_q    <= 1'b0;
      sc_success_q <= 1'b0;
    end else begin
      ll_bit_q     <= (state_nx == LINKED);
      mem_req_q    <= (state_nx == SC_WAIT);
      sc_done_q    <= (state_nx == SC_RESP);
      sc_success_q <= (state_nx == SC_RESP) & result_nx;
    end
  end

  assign bus.LLbit_o      = ll_bit_q;
  assign bus.link_addr_o  = link_addr;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.sc_done_o    = sc_done_q;
  assign bus.sc_success_o = sc_success_q;
  assign bus.stallreq_o   = bus.sc_req & ~sc_done_q;

endmodule
